// File: rtl/si_wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter slice: default widths and requester slot indices.
// The optional forwarding outputs are enabled by defining WB_FWD_EN at build time.
package si_wb_arbiter_pkg;

    localparam int REG_DW_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int NUM_REQ_DEF = 3;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_LSU = 2'd1,
        WB_SRC_MDU = 2'd2
    } wb_src_e;

    // Requester index width: clog2(n), but never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/si_wb_arbiter_if.sv
// Requester/regfile-side bus of the write-back arbiter; fwd_* exists only with WB_FWD_EN defined.
interface si_wb_arbiter_if
    import si_wb_arbiter_pkg::*;
#(
    parameter int REG_DW  = REG_DW_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int REQ_IW  = idx_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*REG_AW-1:0] req_addr_i;
    logic [NUM_REQ*REG_DW-1:0] req_data_i;
    logic                      hold_i;
    logic                      wb_en_o;
    logic [REG_AW-1:0]         wb_addr_o;
    logic [REG_DW-1:0]         wb_data_o;
    logic [REQ_IW-1:0]         wb_src_o;
`ifdef WB_FWD_EN
    logic                      fwd_valid_o;
    logic [REG_AW-1:0]         fwd_addr_o;
    logic [REG_DW-1:0]         fwd_data_o;
`endif

    // Requesters plus the regfile port owner.
    modport master (
        output req_valid_i, req_addr_i, req_data_i, hold_i,
        input  req_ready_o, wb_en_o, wb_addr_o, wb_data_o, wb_src_o
`ifdef WB_FWD_EN
        , input fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
    );

    // The arbiter itself.
    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, hold_i,
        output req_ready_o, wb_en_o, wb_addr_o, wb_data_o, wb_src_o
`ifdef WB_FWD_EN
        , output fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
    );

endinterface

// File: rtl/si_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping modulo N.
module si_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic found;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        if (en_i) begin
            // Walk distances from the pointer; constant indices keep the loop unrollable.
            for (int d = 0; d < N; d++) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && req_i[k] && (((int'(ptr_i) + d) % N) == k)) begin
                        gnt_o[k]  = 1'b1;
                        gnt_idx_o = IW'(k);
                        found     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/si_wb_arbiter.sv
// Round-robin write-back arbiter with x0 drop filter and one registered regfile write port.
// Define WB_FWD_EN to add combinational fwd_* copies of the winning request.
module si_wb_arbiter
    import si_wb_arbiter_pkg::*;
#(
    parameter int REG_DW  = REG_DW_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int REQ_IW  = idx_width(NUM_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    si_wb_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0] x0_req;
    logic [NUM_REQ-1:0] nz_req;
    logic [NUM_REQ-1:0] gnt;
    logic [REQ_IW-1:0]  gnt_idx;
    logic               gnt_vld;
    logic [REG_AW-1:0]  win_addr;
    logic [REG_DW-1:0]  win_data;

    logic [REQ_IW-1:0]  ptr_q,     ptr_d;
    logic               wb_en_q,   wb_en_d;
    logic [REG_AW-1:0]  wb_addr_q, wb_addr_d;
    logic [REG_DW-1:0]  wb_data_q, wb_data_d;
    logic [REQ_IW-1:0]  wb_src_q,  wb_src_d;

    // Writes to x0 are acknowledged and dropped; only the rest compete for the port.
    always_comb begin
        x0_req = '0;
        nz_req = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.req_valid_i[k]) begin
                if (bus.req_addr_i[k*REG_AW +: REG_AW] == '0) x0_req[k] = 1'b1;
                else                                         nz_req[k] = 1'b1;
            end
        end
    end

    si_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (REQ_IW)
    ) u_rr (
        .req_i     (nz_req),
        .en_i      (rst && !bus.hold_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign gnt_vld         = |gnt;
    assign bus.req_ready_o = rst ? (x0_req | gnt) : '0;

    // One-hot grant lets the winner be selected with an AND-OR mux.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                win_addr = win_addr | bus.req_addr_i[k*REG_AW +: REG_AW];
                win_data = win_data | bus.req_data_i[k*REG_DW +: REG_DW];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        wb_en_d   = gnt_vld;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_src_d  = wb_src_q;
        if (gnt_vld) begin
            ptr_d     = (gnt_idx == REQ_IW'(NUM_REQ - 1)) ? '0 : gnt_idx + REQ_IW'(1);
            wb_addr_d = win_addr;
            wb_data_d = win_data;
            wb_src_d  = gnt_idx;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_src_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_src_q  <= wb_src_d;
        end
    end

    assign bus.wb_en_o   = wb_en_q;
    assign bus.wb_addr_o = wb_addr_q;
    assign bus.wb_data_o = wb_data_q;
    assign bus.wb_src_o  = wb_src_q;

`ifdef WB_FWD_EN
    // Grant is already gated by reset, so these read zero in reset and when idle.
    assign bus.fwd_valid_o = gnt_vld;
    assign bus.fwd_addr_o  = win_addr;
    assign bus.fwd_data_o  = win_data;
`endif

endmodule

// File: tb/tb_si_wb_arbiter.sv
// Scoreboard bench for si_wb_arbiter: a round-robin model pushes expected writes, the wb_* monitor pops them.
// Also checks fwd_* when built with WB_FWD_EN.
module tb_si_wb_arbiter;
    import si_wb_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 3;
    localparam int IW = 2;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] src;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    si_wb_arbiter_if #(.REG_DW(DW), .REG_AW(AW), .NUM_REQ(N), .REQ_IW(IW)) bus ();

    si_wb_arbiter #(.REG_DW(DW), .REG_AW(AW), .NUM_REQ(N), .REQ_IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_exp_t       sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [N-1:0]  v;
    logic [AW-1:0] a[N];
    logic [DW-1:0] d[N];
    logic          hold;
    int            m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus.req_valid_i = v;
        bus.hold_i      = hold;
        for (int k = 0; k < N; k++) begin
            bus.req_addr_i[k*AW +: AW] = a[k];
            bus.req_data_i[k*DW +: DW] = d[k];
        end
    endtask

    // One arbitration cycle; entered just after a rising edge with inputs applied.
    // mode 0: acked requesters drop valid; mode 1: acked requesters stay valid with new data.
    task automatic cycle(input int mode);
        logic [N-1:0] exp_rdy;
        wb_exp_t      e;
        int           win;
        int           k;
        exp_rdy = '0;
        win     = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && a[i] == '0) exp_rdy[i] = 1'b1;
        if (!hold) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (win < 0 && v[k] && a[k] != '0) win = k;
            end
        end
        e.en   = (win >= 0);
        e.addr = (win >= 0) ? a[win] : '0;
        e.data = (win >= 0) ? d[win] : '0;
        e.src  = (win >= 0) ? IW'(win) : '0;
        if (win >= 0) exp_rdy[win] = 1'b1;

        @(negedge clk);
        check("req_ready", bus.req_ready_o, exp_rdy);
`ifdef WB_FWD_EN
        check("fwd_valid", bus.fwd_valid_o, e.en);
        if (e.en) begin
            check("fwd_addr", bus.fwd_addr_o, e.addr);
            check("fwd_data", bus.fwd_data_o, e.data);
        end
`endif
        sb_q.push_back(e);
        if (win >= 0) m_ptr = (win + 1) % N;

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("wb_en", bus.wb_en_o, e.en);
        if (e.en) begin
            check("wb_addr", bus.wb_addr_o, e.addr);
            check("wb_data", bus.wb_data_o, e.data);
            check("wb_src",  bus.wb_src_o,  e.src);
        end
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                if (mode == 0) v[i] = 1'b0;
                else           d[i] = $urandom;
            end
        end
        apply();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   bus.req_ready_o, '0);
        check({tag, "_wb_en"},   bus.wb_en_o,     '0);
        check({tag, "_wb_addr"}, bus.wb_addr_o,   '0);
        check({tag, "_wb_data"}, bus.wb_data_o,   '0);
        check({tag, "_wb_src"},  bus.wb_src_o,    '0);
`ifdef WB_FWD_EN
        check({tag, "_fwd_valid"}, bus.fwd_valid_o, '0);
`endif
    endtask

    initial begin
        v     = '1;
        a[0]  = AW'(1);
        a[1]  = AW'(2);
        a[2]  = AW'(3);
        for (int i = 0; i < N; i++) d[i] = $urandom;
        hold  = 1'b0;
        m_ptr = 0;
        apply();
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_clk");
        rst = 1'b1;

        // All continuously valid: grants 0,1,2,0,1,2 back to back.
        repeat (6) cycle(1);

        v = '0;
        apply();
        cycle(0);

        // Single request on slot 1.
        v    = 3'b010;
        a[1] = AW'(5);
        d[1] = 32'hDEAD_BEEF;
        apply();
        cycle(0);
        cycle(0);

        // x0 on slot 0 alongside a real write on slot 2.
        v    = 3'b101;
        a[0] = '0;
        a[2] = AW'(7);
        d[2] = $urandom;
        apply();
        cycle(0);
        v    = '1;
        a[0] = AW'(1);
        a[1] = AW'(2);
        a[2] = AW'(3);
        apply();
        cycle(1);

        // Hold for three cycles with slot 1 waiting.
        v    = 3'b010;
        a[1] = AW'(9);
        d[1] = $urandom;
        hold = 1'b1;
        apply();
        repeat (3) cycle(0);
        hold = 1'b0;
        apply();
        cycle(0);

        // Random traffic, including x0 requests and hold.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(2) != 0) begin
                    v[i] = 1'b1;
                    a[i] = ($urandom_range(3) == 0) ? '0 : AW'($urandom_range(31, 1));
                    d[i] = $urandom;
                end
            end
            hold = ($urandom_range(4) == 0);
            apply();
            cycle(0);
        end

        // Asynchronous reset while a write sits in the output register.
        v    = '1;
        a[0] = AW'(1);
        a[1] = AW'(2);
        a[2] = AW'(3);
        hold = 1'b0;
        apply();
        cycle(1);
        for (int i = 0; i < N && m_ptr == 0; i++) cycle(1);
        check("pre_rst_wb_en", bus.wb_en_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_ptr = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) cycle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/si_wb_arbiter.md
Name: si_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ write-back requesters (ALU pipe, LSU, multi-cycle MDU).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the granted write one cycle before the register file.
- Sits between the execute/memory units and the register file write port; the downstream write-back mux feeds one requester slot.

Parameters:
- REG_DW, 32, register data width
- REG_AW, 5, register address width
- NUM_REQ, 3, number of requesters (2..8)
- REQ_IW, 2, width of the requester index (clog2(NUM_REQ), min 1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset; rst==0 resets all state immediately
- req_valid_i  in  NUM_REQ  per-requester write request
- req_ready_o  out  NUM_REQ  per-requester accept, combinational
- req_addr_i  in  NUM_REQ*REG_AW  flattened dest addresses; requester k at [k*REG_AW +: REG_AW]
- req_data_i  in  NUM_REQ*REG_DW  flattened write data, same packing
- hold_i  in  1  regfile port unavailable this cycle; no grants
- wb_en_o  out  1  registered regfile write enable
- wb_addr_o  out  REG_AW  registered write address
- wb_data_o  out  REG_DW  registered write data
- wb_src_o  out  REG_IW  index of the requester that produced the current write

Behaviour:
- Reset (rst==0, async): wb_en_o=0, wb_addr_o=0, wb_data_o=0, wb_src_o=0, rr pointer ptr=0. req_ready_o is forced to 0 while rst==0.
- A transfer on requester k happens when req_valid_i[k] && req_ready_o[k] at a rising edge. Requesters hold valid, addr and data stable until ready; they must not withdraw valid.
- x0 filter: a valid request with addr==0 gets ready=1 in the same cycle, independent of arbitration and hold_i. It is dropped: no wb_en_o, no pointer update. Several x0 requests in one cycle are all acked.
- Arbitration among valid, non-zero-address requests with hold_i==0:
  - Search starts at ptr and wraps modulo NUM_REQ; the first valid requester k wins.
  - req_ready_o[k]=1; all other non-x0 readies are 0.
- Pointer update: on a grant to k, ptr <= (k+1) mod NUM_REQ at the clock edge. With no grant, ptr holds.
- Output register:
  - Next cycle after a grant: wb_en_o=1, wb_addr_o/wb_data_o = the granted request's values, wb_src_o=k. Latency is exactly 1 cycle from transfer to write enable.
  - With no grant, wb_en_o <= 0; wb_addr_o, wb_data_o and wb_src_o hold their last values.
- Throughput is one write per cycle, back-to-back. The output register never back-pressures because the regfile write completes in one cycle.
- hold_i==1: no non-x0 grants, ptr holds, wb_en_o <= 0 next cycle. A write already in wb_* when hold_i rises still completes.
- Same-address conflicts in one cycle: serialized by round-robin order. Ordering between units is the issue logic's responsibility, not this block's.
- Starvation bound: a continuously valid requester is granted within NUM_REQ arbitration cycles in which hold_i==0.
- Reset mid-operation: the pending output write is discarded (wb_en_o=0 immediately); unaccepted requests remain the requesters' responsibility.

Optional Feature:
- WB_FWD_EN defined adds three outputs:
  - fwd_valid_o (1): =1 when a non-x0 grant occurs this cycle
  - fwd_addr_o (REG_AW)
  - fwd_data_o (REG_DW)
- These are combinational copies of the winning request, for decode-stage forwarding one cycle ahead of the regfile write. All three are 0 during reset and when there is no grant.
- WB_FWD_EN undefined: these ports do not exist and there is no extra logic.

Decomposition:
- Shared defines header: the REG_DW/REG_AW defaults, the requester index constants (WB_SRC_ALU=0, WB_SRC_LSU=1, WB_SRC_MDU=2) and the WB_FWD_EN switch.
- One sub-module, si_rr_arbiter:
  - parameter N; inputs req[N], en, ptr; outputs a one-hot grant and the grant index.
  - Purely combinational.
- The pointer and output registers stay in si_wb_arbiter.

Test Plan:
- Reset: drive rst=0 with all valids=1 -> wb_en_o=0, all wb_* outputs 0, req_ready_o=0; release rst, the first grant goes to requester 0.
- Single request: req 1 valid, addr=5, data=0xDEADBEEF -> ready[1]=1 in cycle T; at T+1 wb_en_o=1, wb_addr_o=5, wb_data_o=0xDEADBEEF, wb_src_o=1; at T+2 wb_en_o=0.
- All three continuously valid with addrs 1/2/3 -> grant order 0,1,2,0,1,2; wb_en_o high every cycle with the matching addr and data.
- x0 filter: req 0 addr=0 and req 2 addr=7 valid in the same cycle -> ready[0]=1 and ready[2]=1; the next cycle writes only addr 7; ptr advances to 0 (from grant 2).
- hold_i=1 for 3 cycles with req 1 valid -> ready[1]=0 and wb_en_o=0 throughout; grant on the first cycle after hold_i drops; ptr unchanged during hold.
- Assert rst=0 asynchronously mid-cycle while wb_en_o=1 -> wb_en_o drops before the next edge; ptr=0. With WB_FWD_EN defined, fwd_valid_o=0 during reset.
